// File: rtl/risc16_pkg.sv
// Shared widths and control encodings for the risc16 execute core.
package risc16_pkg;

  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int AW   = $clog2(NREG);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_NOT = 3'b010,
    ALU_SHL = 3'b011,
    ALU_SHR = 3'b100,
    ALU_AND = 3'b101,
    ALU_OR  = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  // Codes 6 and 7 are reserved and never take a branch.
  typedef enum logic [2:0] {
    BR_EQ = 3'd0,
    BR_NE = 3'd1,
    BR_LT = 3'd2,
    BR_LE = 3'd3,
    BR_GT = 3'd4,
    BR_GE = 3'd5
  } br_cond_e;

endpackage

// File: rtl/risc16_regfile.sv
// 8x16 register file: two asynchronous read ports, one synchronous write port.
import risc16_pkg::*;

module risc16_regfile (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // No bypass: a same-cycle read of the write target sees the old value.
  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/risc16_exec_core.sv
// Execute core: register file, ALU with registered zero/neg flags, branch condition select.
import risc16_pkg::*;

module risc16_exec_core (
  input  logic          clk,
  input  logic          rst,
  input  logic          regw_en,
  input  logic [AW-1:0] inrw,
  input  logic [DW-1:0] regw_data,
  input  logic [AW-1:0] inrr1,
  input  logic [AW-1:0] inrr2,
  output logic [DW-1:0] regr_data1,
  output logic [DW-1:0] regr_data2,
  input  logic [DW-1:0] alu_a,
  input  logic [DW-1:0] alu_b,
  input  logic [2:0]    alu_ctrl,
  input  logic          upd_flag,
  output logic [DW-1:0] alu_result,
  output logic          zero,
  output logic          neg,
  input  logic          b,
  input  logic [2:0]    cond_sel,
  output logic          branch_taken
);

  logic cond;

  risc16_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (regw_en),
    .waddr  (inrw),
    .wdata  (regw_data),
    .raddr1 (inrr1),
    .raddr2 (inrr2),
    .rdata1 (regr_data1),
    .rdata2 (regr_data2)
  );

  always_comb begin
    alu_result = '0;
    case (alu_op_e'(alu_ctrl))
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_NOT: alu_result = ~alu_a;
      ALU_SHL: alu_result = alu_a << alu_b[3:0];
      ALU_SHR: alu_result = alu_a >> alu_b[3:0];
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_SLT: alu_result = {{(DW-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zero <= 1'b0;
      neg  <= 1'b0;
    end else if (upd_flag) begin
      zero <= (alu_result == '0);
      neg  <= alu_result[DW-1];
    end
  end

  always_comb begin
    cond = 1'b0;
    case (br_cond_e'(cond_sel))
      BR_EQ:   cond = zero;
      BR_NE:   cond = ~zero;
      BR_LT:   cond = neg;
      BR_LE:   cond = neg | zero;
      BR_GT:   cond = ~neg & ~zero;
      BR_GE:   cond = ~neg;
      default: cond = 1'b0;
    endcase
  end

  assign branch_taken = b & cond;

endmodule

// File: tb/tb_risc16_exec_core.sv
// Bench for risc16_exec_core: directed cases plus random traffic against a behavioural model.
module tb_risc16_exec_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        regw_en;
  logic [2:0]  inrw;
  logic [15:0] regw_data;
  logic [2:0]  inrr1;
  logic [2:0]  inrr2;
  logic [15:0] regr_data1;
  logic [15:0] regr_data2;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic        upd_flag;
  logic [15:0] alu_result;
  logic        zero;
  logic        neg;
  logic        b;
  logic [2:0]  cond_sel;
  logic        branch_taken;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] m_reg [8];
  logic        m_zero;
  logic        m_neg;

  always #5 clk = ~clk;

  risc16_exec_core dut (
    .clk          (clk),
    .rst          (rst),
    .regw_en      (regw_en),
    .inrw         (inrw),
    .regw_data    (regw_data),
    .inrr1        (inrr1),
    .inrr2        (inrr2),
    .regr_data1   (regr_data1),
    .regr_data2   (regr_data2),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctrl     (alu_ctrl),
    .upd_flag     (upd_flag),
    .alu_result   (alu_result),
    .zero         (zero),
    .neg          (neg),
    .b            (b),
    .cond_sel     (cond_sel),
    .branch_taken (branch_taken)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] bb);
    int sa, sb;
    sa = a[15]  ? int'(a)  - 65536 : int'(a);
    sb = bb[15] ? int'(bb) - 65536 : int'(bb);
    case (op)
      3'd0:    return 16'((int'(a) + int'(bb)) % 65536);
      3'd1:    return 16'((int'(a) - int'(bb) + 65536) % 65536);
      3'd2:    return 16'(65535 - int'(a));
      3'd3:    return 16'((int'(a) * (1 << int'(bb[3:0]))) % 65536);
      3'd4:    return 16'(int'(a) / (1 << int'(bb[3:0])));
      3'd5:    return a & bb;
      3'd6:    return a | bb;
      default: return (sa < sb) ? 16'd1 : 16'd0;
    endcase
  endfunction

  function automatic logic ref_br(input logic [2:0] sel, input logic bb, input logic z, input logic n);
    if (!bb) return 1'b0;
    case (sel)
      3'd0:    return z;
      3'd1:    return !z;
      3'd2:    return n;
      3'd3:    return n || z;
      3'd4:    return !n && !z;
      3'd5:    return !n;
      default: return 1'b0;
    endcase
  endfunction

  // One clock edge; the model commits whatever the inputs request, then settle 1ns.
  task automatic step();
    logic [15:0] r;
    @(posedge clk);
    if (rst) begin
      r = ref_alu(alu_ctrl, alu_a, alu_b);
      if (regw_en) m_reg[inrw] = regw_data;
      if (upd_flag) begin
        m_zero = (r == 16'h0000);
        m_neg  = r[15];
      end
    end
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
    m_zero = 1'b0;
    m_neg  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      inrr1 = 3'(i);
      inrr2 = 3'(7 - i);
      #1;
      check({tag, "_rd1"}, regr_data1, 16'h0000);
      check({tag, "_rd2"}, regr_data2, 16'h0000);
    end
    check({tag, "_zero"}, 16'(zero), 16'h0000);
    check({tag, "_neg"},  16'(neg),  16'h0000);
  endtask

  logic [15:0] sweep_exp [8];
  logic [7:0]  br_exp;

  initial begin
    sweep_exp = '{16'h000C, 16'hFFFE, 16'hFFFA, 16'h0280, 16'h0000, 16'h0005, 16'h0007, 16'h0001};
    br_exp    = 8'b0010_1001;   // bit i = expected branch_taken for cond_sel i with zero=1, neg=0

    rst = 1'b0; regw_en = 1'b0; inrw = '0; regw_data = '0; inrr1 = '0; inrr2 = '0;
    alu_a = '0; alu_b = '0; alu_ctrl = '0; upd_flag = 1'b0; b = 1'b0; cond_sel = '0;
    model_reset();
    #2;
    check_all_zero("reset_init");
    @(negedge clk);
    rst = 1'b1;

    // Register write / read, and no write-through bypass
    regw_en = 1'b1; inrw = 3'd3; regw_data = 16'h1234; step();
    @(negedge clk); inrw = 3'd7; regw_data = 16'hFFFF; step();
    @(negedge clk); regw_en = 1'b0; inrr1 = 3'd3; inrr2 = 3'd7; #1;
    check("rd_r3", regr_data1, 16'h1234);
    check("rd_r7", regr_data2, 16'hFFFF);
    @(negedge clk); regw_en = 1'b1; inrw = 3'd3; regw_data = 16'h5555; inrr2 = 3'd3; #1;
    check("rd_old_r3", regr_data1, 16'h1234);
    check("rd_old_r3_p2", regr_data2, 16'h1234);
    step();
    check("rd_new_r3", regr_data1, 16'h5555);
    check("rd_new_r3_p2", regr_data2, 16'h5555);
    @(negedge clk); regw_en = 1'b0;

    // ALU sweep
    alu_a = 16'h0005; alu_b = 16'h0007;
    for (int op = 0; op < 8; op++) begin
      alu_ctrl = 3'(op); #1;
      check($sformatf("alu_sweep_op%0d", op), alu_result, sweep_exp[op]);
    end
    alu_a = 16'h8000; alu_b = 16'h0001;
    alu_ctrl = 3'd7; #1; check("alu_slt_neg", alu_result, 16'h0001);
    alu_ctrl = 3'd0; #1; check("alu_add_msb", alu_result, 16'h8001);

    // Flags: update, then hold
    @(negedge clk); alu_a = 16'h0005; alu_b = 16'h0007; alu_ctrl = 3'd1; upd_flag = 1'b1; step();
    check("flag_neg_set", 16'(neg), 16'h0001);
    check("flag_zero_clr", 16'(zero), 16'h0000);
    @(negedge clk); alu_a = 16'h0000; alu_b = 16'h0000; alu_ctrl = 3'd0; upd_flag = 1'b0; step();
    check("flag_neg_hold", 16'(neg), 16'h0001);
    check("flag_zero_hold", 16'(zero), 16'h0000);

    // Branch select with zero=1, neg=0
    @(negedge clk); upd_flag = 1'b1; step();
    @(negedge clk); upd_flag = 1'b0;
    check("br_pre_zero", 16'(zero), 16'h0001);
    check("br_pre_neg", 16'(neg), 16'h0000);
    for (int c = 0; c < 8; c++) begin
      cond_sel = 3'(c);
      b = 1'b1; #1; check($sformatf("br_b1_sel%0d", c), 16'(branch_taken), 16'(br_exp[c]));
      b = 1'b0; #1; check($sformatf("br_b0_sel%0d", c), 16'(branch_taken), 16'h0000);
    end

    // Random traffic against the model
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      regw_en   = 1'($urandom_range(0, 1));
      inrw      = 3'($urandom_range(0, 7));
      regw_data = 16'($urandom);
      inrr1     = 3'($urandom_range(0, 7));
      inrr2     = 3'($urandom_range(0, 7));
      alu_a     = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      alu_b     = ($urandom_range(0, 3) == 0) ? alu_a : 16'($urandom);
      alu_ctrl  = 3'($urandom_range(0, 7));
      upd_flag  = 1'($urandom_range(0, 1));
      b         = 1'($urandom_range(0, 3) != 0);
      cond_sel  = 3'($urandom_range(0, 7));
      #1;
      check("rnd_rd1", regr_data1, m_reg[inrr1]);
      check("rnd_rd2", regr_data2, m_reg[inrr2]);
      check("rnd_alu", alu_result, ref_alu(alu_ctrl, alu_a, alu_b));
      check("rnd_zero", 16'(zero), 16'(m_zero));
      check("rnd_neg", 16'(neg), 16'(m_neg));
      check("rnd_br", 16'(branch_taken), 16'(ref_br(cond_sel, b, m_zero, m_neg)));
      step();
    end

    // Mid-run asynchronous reset with a write and flag update pending
    @(negedge clk);
    regw_en = 1'b1; inrw = 3'd5; regw_data = 16'hBEEF;
    alu_a = 16'h8000; alu_b = 16'h0000; alu_ctrl = 3'd0; upd_flag = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    check_all_zero("reset_async");
    step();
    check_all_zero("reset_held");
    @(negedge clk);
    rst = 1'b1;
    regw_en = 1'b0; upd_flag = 1'b0;
    inrr1 = 3'd5; #1;
    check("post_reset_r5", regr_data1, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
